// File: rtl/crp16_boot_controller_pkg.sv
// Shared types and constants for the crp16 boot controller: state encoding,
// the STOP instruction pattern and the post-release settle window.
package crp16_boot_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_DUMP = 3'd3,
    ST_DONE = 3'd4
  } boot_state_t;

  localparam logic [15:0] HALT_INSTR = 16'h8000;
  localparam logic [31:0] RUN_SETTLE = 32'd3;

endpackage

// File: rtl/crp16_boot_controller_port_b_mux.sv
// Combinational 2:1 select of RAM port B between the boot loader and the CPU.
module crp16_port_b_mux
  import crp16_boot_controller_pkg::*;
(
  input  logic        i_load_active,
  input  logic [15:0] i_ctl_address,
  input  logic [15:0] i_ctl_data,
  input  logic        i_ctl_wren,
  input  logic [15:0] i_cpu_address,
  input  logic [15:0] i_cpu_data,
  input  logic        i_cpu_wren,
  output logic [15:0] o_ram_address,
  output logic [15:0] o_ram_data,
  output logic        o_ram_wren
);

  assign o_ram_address = i_load_active ? i_ctl_address : i_cpu_address;
  assign o_ram_data    = i_load_active ? i_ctl_data    : i_cpu_data;
  assign o_ram_wren    = i_load_active ? i_ctl_wren    : i_cpu_wren;

endmodule

// File: rtl/crp16_boot_controller.sv
// Host-side sequencer for a crp16_datapath run: load image, run to STOP, dump registers.
// Optional run watchdog enabled by defining CRP16_BOOT_WATCHDOG_EN.
module crp16_boot_controller
  import crp16_boot_controller_pkg::*;
#(
  parameter logic [15:0] LOAD_BASE  = 16'h0000,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] WDT_CYCLES = 32'd1000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] load_len,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [15:0] out_data,
  input  logic        out_ready,
  output logic        cpu_reset,
  input  logic [15:0] cpu_address_b,
  input  logic [15:0] cpu_data_b,
  input  logic        cpu_wren_b,
  output logic [15:0] ram_address_b,
  output logic [15:0] ram_data_b,
  output logic        ram_wren_b,
  input  logic [15:0] instr_view,
  output logic [2:0]  reg_sel,
  input  logic [15:0] reg_view,
  output logic        busy,
  output logic        done,
  output logic        timed_out,
  output logic [31:0] run_cycles
);

`ifdef CRP16_BOOT_WATCHDOG_EN
  localparam bit WDT_EN = 1'b1;
`else
  localparam bit WDT_EN = 1'b0;
`endif

  localparam logic [2:0] LAST_REG = 3'(NUM_REGS - 1);

  boot_state_t r_state;
  logic        r_cpu_reset;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [2:0]  r_reg_sel;
  logic        r_busy;
  logic        r_done;
  logic        r_timed_out;
  logic [31:0] r_run_cycles;
  logic [15:0] r_cnt;
  logic [15:0] r_len;

  logic        w_load_active;
  logic        w_load_wr;
  logic        w_halt_seen;
  logic        w_wdt_hit;

  assign w_load_active = (r_state == ST_LOAD);
  // A handshake coinciding with abort or reset never reaches the RAM.
  assign w_load_wr     = w_load_active & in_valid & ~abort & ~reset;
  assign w_halt_seen   = (r_run_cycles >= RUN_SETTLE) && (instr_view == HALT_INSTR);
  assign w_wdt_hit     = WDT_EN && (r_run_cycles >= (WDT_CYCLES - 32'd1));

  crp16_port_b_mux u_port_b_mux (
    .i_load_active (w_load_active),
    .i_ctl_address (LOAD_BASE + r_cnt),
    .i_ctl_data    (in_data),
    .i_ctl_wren    (w_load_wr),
    .i_cpu_address (cpu_address_b),
    .i_cpu_data    (cpu_data_b),
    .i_cpu_wren    (cpu_wren_b),
    .o_ram_address (ram_address_b),
    .o_ram_data    (ram_data_b),
    .o_ram_wren    (ram_wren_b)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_cpu_reset  <= 1'b1;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_reg_sel    <= 3'd0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_timed_out  <= 1'b0;
      r_run_cycles <= 32'd0;
      r_cnt        <= 16'd0;
    end else if (abort) begin
      r_state     <= ST_IDLE;
      r_cpu_reset <= 1'b1;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timed_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_run_cycles <= 32'd0;
            r_timed_out  <= 1'b0;
            r_done       <= 1'b0;
            r_busy       <= 1'b1;
            r_cnt        <= 16'd0;
            r_len        <= load_len;
            r_reg_sel    <= 3'd0;
            if (load_len != 16'd0) begin
              r_state     <= ST_LOAD;
              r_cpu_reset <= 1'b1;
              r_in_ready  <= 1'b1;
            end else begin
              r_state     <= ST_RUN;
              r_cpu_reset <= 1'b0;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == r_len - 16'd1) begin
              r_state     <= ST_RUN;
              r_in_ready  <= 1'b0;
              r_cpu_reset <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (r_run_cycles != 32'hFFFF_FFFF) r_run_cycles <= r_run_cycles + 32'd1;
          if (w_halt_seen) begin
            r_state     <= ST_DUMP;
            r_out_valid <= 1'b1;
            r_reg_sel   <= 3'd0;
          end else if (w_wdt_hit) begin
            r_state     <= ST_DONE;
            r_timed_out <= 1'b1;
            r_done      <= 1'b1;
            r_busy      <= 1'b0;
            r_cpu_reset <= 1'b1;
          end
        end
        ST_DUMP: begin
          if (out_ready) begin
            r_reg_sel <= r_reg_sel + 3'd1;
            if (r_reg_sel == LAST_REG) begin
              r_state     <= ST_DONE;
              r_out_valid <= 1'b0;
              r_done      <= 1'b1;
              r_busy      <= 1'b0;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_reset  = r_cpu_reset;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = reg_view;
  assign reg_sel    = r_reg_sel;
  assign busy       = r_busy;
  assign done       = r_done;
  assign timed_out  = r_timed_out;
  assign run_cycles = r_run_cycles;

endmodule

// File: tb/tb_crp16_boot_controller.sv
// Directed bench for crp16_boot_controller: load, run-to-halt, dump, stall, abort, zero-length start.
module tb_crp16_boot_controller;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [15:0] load_len;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ready;
  logic        cpu_reset;
  logic [15:0] cpu_address_b;
  logic [15:0] cpu_data_b;
  logic        cpu_wren_b;
  logic [15:0] ram_address_b;
  logic [15:0] ram_data_b;
  logic        ram_wren_b;
  logic [15:0] instr_view;
  logic [2:0]  reg_sel;
  logic [15:0] reg_view;
  logic        busy;
  logic        done;
  logic        timed_out;
  logic [31:0] run_cycles;

  logic [15:0] regs [8];
  int n_vec;
  int n_err;

  assign reg_view = regs[reg_sel];

  crp16_boot_controller dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .abort         (abort),
    .load_len      (load_len),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_ready     (out_ready),
    .cpu_reset     (cpu_reset),
    .cpu_address_b (cpu_address_b),
    .cpu_data_b    (cpu_data_b),
    .cpu_wren_b    (cpu_wren_b),
    .ram_address_b (ram_address_b),
    .ram_data_b    (ram_data_b),
    .ram_wren_b    (ram_wren_b),
    .instr_view    (instr_view),
    .reg_sel       (reg_sel),
    .reg_view      (reg_view),
    .busy          (busy),
    .done          (done),
    .timed_out     (timed_out),
    .run_cycles    (run_cycles)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

  initial begin
    int idx;
    n_vec = 0;
    n_err = 0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; load_len = 16'd0;
    in_valid = 1'b0; in_data = 16'd0; out_ready = 1'b0;
    cpu_address_b = 16'd0; cpu_data_b = 16'd0; cpu_wren_b = 1'b0;
    instr_view = 16'd0;
    regs[0] = 16'h0000; regs[1] = 16'h0005; regs[2] = 16'hA002; regs[3] = 16'hA003;
    regs[4] = 16'hA004; regs[5] = 16'hA005; regs[6] = 16'hA006; regs[7] = 16'hA007;

    // reset state
    tick(); tick(); #1;
    chk("rst_cpu_reset", cpu_reset, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_reg_sel", reg_sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timed_out", timed_out, 0);
    chk("rst_run_cycles", run_cycles, 0);
    reset = 1'b0;

    // 3-word load with in_valid held high
    start = 1'b1; load_len = 16'd3; in_valid = 1'b1; in_data = 16'h0001;
    tick(); start = 1'b0; #1;
    chk("t1_in_ready", in_ready, 1);
    chk("t1_busy", busy, 1);
    chk("t1_cpu_reset_load", cpu_reset, 1);
    chk("t1_wren0", ram_wren_b, 1);
    chk("t1_addr0", ram_address_b, 16'h0000);
    chk("t1_data0", ram_data_b, 16'h0001);
    tick(); in_data = 16'h2343; #1;
    chk("t1_wren1", ram_wren_b, 1);
    chk("t1_addr1", ram_address_b, 16'h0001);
    chk("t1_data1", ram_data_b, 16'h2343);
    tick(); in_data = 16'h8000; #1;
    chk("t1_wren2", ram_wren_b, 1);
    chk("t1_addr2", ram_address_b, 16'h0002);
    chk("t1_data2", ram_data_b, 16'h8000);
    tick(); #1;
    chk("t1_run_cpu_reset", cpu_reset, 0);
    chk("t1_run_in_ready", in_ready, 0);
    chk("t1_run_wren", ram_wren_b, 0);
    chk("t1_run_cycles0", run_cycles, 0);

    // STOP visible from the first RUN cycle; ignored during settle
    in_valid = 1'b0; instr_view = 16'h8000;
    tick(); tick(); tick(); #1;
    chk("t2_settle_cycles", run_cycles, 3);
    chk("t2_settle_no_dump", out_valid, 0);
    out_ready = 1'b1;
    tick(); instr_view = 16'h0000; #1;
    chk("t2_run_cycles_halt", run_cycles, 4);
    for (int i = 0; i < 8; i++) begin
      chk("t2_dump_valid", out_valid, 1);
      chk("t2_dump_sel", reg_sel, i);
      chk("t2_dump_data", out_data, regs[i]);
      tick(); #1;
    end
    chk("t2_done", done, 1);
    chk("t2_done_valid", out_valid, 0);
    chk("t2_done_busy", busy, 0);
    chk("t2_done_cpu_reset", cpu_reset, 0);
    chk("t2_done_run_cycles", run_cycles, 4);
    out_ready = 1'b0;

    // restart from DONE, stalled dump
    start = 1'b1; load_len = 16'd1; in_valid = 1'b1; in_data = 16'h1234;
    tick(); start = 1'b0; #1;
    chk("t3_cpu_reset_reassert", cpu_reset, 1);
    chk("t3_done_cleared", done, 0);
    chk("t3_run_cycles_clear", run_cycles, 0);
    chk("t3_wren", ram_wren_b, 1);
    chk("t3_addr", ram_address_b, 16'h0000);
    tick(); in_valid = 1'b0; instr_view = 16'h8000; #1;
    chk("t3_run_cpu_reset", cpu_reset, 0);
    for (int i = 0; i < 8; i++) regs[i] = 16'hC0D0 + 16'(i);
    tick(); tick(); tick(); tick(); #1;
    idx = 0;
    for (int k = 0; k < 24 && idx < 8; k++) begin
      out_ready = (k % 2 == 1);
      #1;
      chk("t3_dump_valid", out_valid, 1);
      chk("t3_dump_sel", reg_sel, idx);
      chk("t3_dump_data", out_data, regs[idx]);
      if (out_ready) idx++;
      tick();
    end
    out_ready = 1'b0;
    #1;
    chk("t3_transfer_count", idx, 8);
    chk("t3_done", done, 1);
    chk("t3_done_valid", out_valid, 0);

    // abort mid-load, then reload from LOAD_BASE, then abort in RUN
    start = 1'b1; load_len = 16'd5; in_valid = 1'b1; in_data = 16'hAAA0;
    tick(); start = 1'b0; #1;
    chk("t4_wren0", ram_wren_b, 1);
    chk("t4_addr0", ram_address_b, 16'h0000);
    tick(); in_data = 16'hAAA1; #1;
    chk("t4_wren1", ram_wren_b, 1);
    chk("t4_addr1", ram_address_b, 16'h0001);
    tick(); in_data = 16'hAAA2; abort = 1'b1; #1;
    chk("t4_abort_cycle_wren", ram_wren_b, 0);
    tick(); abort = 1'b0; #1;
    chk("t4_idle_cpu_reset", cpu_reset, 1);
    chk("t4_idle_in_ready", in_ready, 0);
    chk("t4_idle_busy", busy, 0);
    chk("t4_idle_done", done, 0);
    chk("t4_idle_wren", ram_wren_b, 0);
    start = 1'b1; load_len = 16'd2; in_data = 16'h5550;
    tick(); start = 1'b0; #1;
    chk("t4_reload_wren", ram_wren_b, 1);
    chk("t4_reload_addr0", ram_address_b, 16'h0000);
    chk("t4_reload_data0", ram_data_b, 16'h5550);
    tick(); in_data = 16'h5551; #1;
    chk("t4_reload_addr1", ram_address_b, 16'h0001);
    tick(); in_valid = 1'b0; #1;
    chk("t4_run_cpu_reset", cpu_reset, 0);
    tick(); tick(); #1;
    chk("t4_run_cycles2", run_cycles, 2);
    abort = 1'b1;
    tick(); abort = 1'b0; #1;
    chk("t4_abort_run_cpu_reset", cpu_reset, 1);
    chk("t4_abort_run_busy", busy, 0);
    chk("t4_abort_run_held", run_cycles, 2);

    // zero-length start goes straight to RUN; port B passthrough
    instr_view = 16'h0000; start = 1'b1; load_len = 16'd0;
    tick(); start = 1'b0; #1;
    chk("t5_cpu_reset", cpu_reset, 0);
    chk("t5_busy", busy, 1);
    chk("t5_in_ready", in_ready, 0);
    chk("t5_run_cycles", run_cycles, 0);
    cpu_address_b = 16'h1357; cpu_data_b = 16'hBEEF; cpu_wren_b = 1'b1; #1;
    chk("t5_pass_addr", ram_address_b, 16'h1357);
    chk("t5_pass_data", ram_data_b, 16'hBEEF);
    chk("t5_pass_wren", ram_wren_b, 1);
    start = 1'b1; load_len = 16'd7;
    tick(); start = 1'b0; #1;
    chk("t5_start_ignored_ready", in_ready, 0);
    chk("t5_start_ignored_cpu", cpu_reset, 0);
    chk("t5_start_ignored_cycles", run_cycles, 1);
    chk("t5_pass_wren_run", ram_wren_b, 1);
    cpu_wren_b = 1'b0; abort = 1'b1;
    tick(); abort = 1'b0; #1;
    chk("t5_abort_cpu_reset", cpu_reset, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crp16_boot_controller.md
Name: crp16_boot_controller

Overview:
Sequences a crp16_datapath run from a host. It holds the CPU in reset and streams a program image into RAM port B. It then releases the CPU, detects the STOP instruction (0x8000) in writeback, and streams all eight register values back to the host. It sits between the host link, the CPU's port-B memory signals and the dual-port RAM; port A stays wired directly CPU↔RAM.

Parameters:
LOAD_BASE, 16'h0000, RAM word address of the first loaded word.
NUM_REGS, 8, number of registers dumped; reg_sel width fixed at 3.
WDT_CYCLES, 32'd1000000, run-cycle limit (used only with the optional feature).

Ports:
clock  in  1  system clock, shared with datapath and RAM
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begins load (accepted in IDLE/DONE only)
abort  in  1  forces IDLE from any state
load_len  in  16  words to load, sampled on accepted start
in_valid / in_data / in_ready  in/in/out  1/16/1  program word stream
out_valid / out_data / out_ready  out/out/in  1/16/1  register dump stream
cpu_reset  out  1  drives datapath reset
cpu_address_b / cpu_data_b / cpu_wren_b  in  16/16/1  CPU port-B request
ram_address_b / ram_data_b / ram_wren_b  out  16/16/1  to RAM port B
instr_view  in  16  datapath writeback instruction
reg_sel  out  3  datapath register view select
reg_view  in  16  datapath register view value (combinational from reg_sel)
busy / done / timed_out  out  1  status
run_cycles  out  32  cycles spent in RUN, saturating at 32'hFFFFFFFF

Behaviour:
- States: IDLE, LOAD, RUN, DUMP, DONE.
- Reset values: IDLE, cpu_reset=1, in_ready=0, out_valid=0, reg_sel=0, busy=0, done=0, timed_out=0, run_cycles=0, word counter=0.
- IDLE:
  - cpu_reset=1.
  - start with load_len≠0 → LOAD: counter=0, run_cycles=0, timed_out=0, done=0.
  - start with load_len=0 → RUN directly.
- LOAD:
  - cpu_reset=1, in_ready=1, busy=1.
  - Port B is driven by the controller. In the same cycle as an in_valid&in_ready handshake: ram_wren_b=1, ram_address_b=LOAD_BASE+counter (16-bit wrap), ram_data_b=in_data. Counter increments.
  - Handshake on word load_len-1 → RUN on the next edge.
  - No handshake in a cycle → ram_wren_b=0.
- Port-B mux: in every state other than LOAD, ram_*_b = cpu_*_b unchanged (zero latency).
- RUN:
  - cpu_reset=0 from the first RUN cycle; busy=1; run_cycles +1 per RUN cycle.
  - instr_view==16'h8000 while in RUN → DUMP next edge.
  - The 0x8000 check is ignored during the first 3 RUN cycles; the pipeline is filling and wb_instr is 0 after reset anyway.
  - cpu_reset stays 0 after halt, so the datapath stays frozen with registers intact.
- DUMP:
  - out_valid=1, reg_sel=index, out_data=reg_view (combinational).
  - out_valid&out_ready → index+1. The handshake at index NUM_REGS-1 → DONE.
  - out_valid never drops while in DUMP; the host may stall indefinitely.
- DONE:
  - done=1, busy=0, cpu_reset=0 (frozen CPU remains viewable).
  - start behaves as from IDLE, re-asserting cpu_reset on entry to LOAD.
- Simultaneous events:
  - abort has priority over all transitions → IDLE, cpu_reset=1, done=0. run_cycles is held.
  - start outside IDLE/DONE is ignored.
  - In-flight stream handshakes on the abort cycle are discarded: no RAM write, no index advance.
- reset mid-operation: identical to the reset values above, regardless of state.

Optional Feature:
CRP16_BOOT_WATCHDOG_EN.
- Defined: in RUN, run_cycles reaching WDT_CYCLES without a halt → DONE next edge, with timed_out=1, cpu_reset=1 and no dump.
- Undefined: no limit; timed_out tied 0; RUN lasts until halt or abort.

Decomposition:
- Shared header crp16_boot_defs.vh:
  - state encodings (3-bit): IDLE=0, LOAD=1, RUN=2, DUMP=3, DONE=4
  - HALT_INSTR=16'h8000
  - RUN_SETTLE=3
- The existing register sub-component is reused for counters.
- One natural sub-module: crp16_port_b_mux, the combinational 2:1 port-B select keyed on a load_active signal.

Test Plan:
1. Load 3 words (0x0001, 0x2343, 0x8000) with in_valid held high → ram_wren_b high for exactly 3 cycles at addresses 0,1,2; RUN entered on the 4th cycle with cpu_reset falling the same cycle.
2. Load a program that sets r1=5 then STOP; out_ready=1 → DUMP emits 8 words in 8 consecutive cycles with word1=0x0005; done=1 next cycle; run_cycles matches the expected pipeline count.
3. Toggle out_ready 1/0 during DUMP → out_data held stable across stall cycles; exactly 8 transfers, in index order 0..7.
4. Pulse abort mid-LOAD after 2 words → IDLE next edge, cpu_reset=1, no further RAM writes; a subsequent start reloads from LOAD_BASE.
5. Start with load_len=0 → RUN immediately, cpu_reset=0 in the cycle after start; the CPU store passes through to RAM port B unmodified.
6. (With CRP16_BOOT_WATCHDOG_EN, WDT_CYCLES=20) load a self-looping jump → timed_out=1, done=1 and cpu_reset=1 after 20 RUN cycles; no out_valid pulse.
